alu_exec_unit: RTL and testbench

Parametrised execute-stage ALU with integrated ALU-op decode and an iterative RV32M multiply/divide datapath. It replaces the combinational ALUop/funct decode plus single-cycle ALU pair in the EX stage. It decodes ALUop/funct7/funct3 into the full RV32I/M operation set and executes single-cycle ops in one cycle and MUL/DIV ops in WIDTH cycles. A valid/ready handshake on both sides lets the pipeline stall cleanly.

---
 rtl/alu_exec_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: RV32I/M decode, single-cycle ALU and iterative mul/div.
// Valid/ready handshake on both sides; one operation in flight at a time.
module alu_exec_unit #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUop,
    input  logic [6:0]       funct7,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;
    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
        OP_OR, OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
        OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_e;

    state_e r_state, w_nxt;
    op_e    w_op, r_op;

    logic [SW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt, w_prod;
    logic [WIDTH-1:0]   r_mplier, r_rem, r_quo, r_dvs, r_result;
    logic               r_neg, r_rneg, r_zero, r_ill;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_res, w_mres, w_dres;
    logic [WIDTH-1:0]   w_rem_nxt, w_quo_nxt, w_q, w_r;
    logic [WIDTH:0]     w_sh, w_diff;
    logic [SW-1:0]      w_sh_amt;
    logic               w_a_sgn, w_b_sgn, w_is_mul, w_is_div;
    logic               w_dz, w_ovf, w_single, w_qbit;

    always_comb begin
        w_op = OP_ILL;
        unique case (ALUop)
            2'b00: w_op = OP_ADD;
            2'b01: w_op = OP_SUB;
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    unique case (funct3)
                        3'b000: w_op = OP_ADD;
                        3'b001: w_op = OP_SLL;
                        3'b010: w_op = OP_SLT;
                        3'b011: w_op = OP_SLTU;
                        3'b100: w_op = OP_XOR;
                        3'b101: w_op = OP_SRL;
                        3'b110: w_op = OP_OR;
                        default: w_op = OP_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000) w_op = OP_SUB;
                    else if (funct3 == 3'b101) w_op = OP_SRA;
                end else if (funct7 == 7'b0000001 && MUL_EN) begin
                    unique case (funct3)
                        3'b000: w_op = OP_MUL;
                        3'b001: w_op = OP_MULH;
                        3'b010: w_op = OP_MULHSU;
                        3'b011: w_op = OP_MULHU;
                        3'b100: w_op = OP_DIV;
                        3'b101: w_op = OP_DIVU;
                        3'b110: w_op = OP_REM;
                        default: w_op = OP_REMU;
                    endcase
                end
            end
            default: begin
                unique case (funct3)
                    3'b000: w_op = OP_ADD;
                    3'b001: w_op = (funct7 == 7'b0) ? OP_SLL : OP_ILL;
                    3'b010: w_op = OP_SLT;
                    3'b011: w_op = OP_SLTU;
                    3'b100: w_op = OP_XOR;
                    3'b101: w_op = funct7[5] ? OP_SRA : OP_SRL;
                    3'b110: w_op = OP_OR;
                    default: w_op = OP_AND;
                endcase
            end
        endcase
    end

    assign w_sh_amt = src_b[SW-1:0];
    assign w_is_mul = w_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU};
    assign w_is_div = w_op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    assign w_a_sgn  = (w_op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM})
                      && src_a[WIDTH-1];
    assign w_b_sgn  = (w_op inside {OP_MULH, OP_DIV, OP_REM})
                      && src_b[WIDTH-1];
    assign w_mag_a  = w_a_sgn ? -src_a : src_a;
    assign w_mag_b  = w_b_sgn ? -src_b : src_b;
    assign w_dz     = (src_b == '0);
    assign w_ovf    = (w_op inside {OP_DIV, OP_REM}) && (src_b == '1)
                      && (src_a == {1'b1, {(WIDTH-1){1'b0}}});
    assign w_single = !w_is_mul && !(w_is_div && !w_dz && !w_ovf);

    // Div special cases resolve here too, so they take the one-cycle path.
    always_comb begin
        w_res = '0;
        unique case (w_op)
            OP_ADD:  w_res = src_a + src_b;
            OP_SUB:  w_res = src_a - src_b;
            OP_SLL:  w_res = src_a << w_sh_amt;
            OP_SLT:  w_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            OP_SLTU: w_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
            OP_XOR:  w_res = src_a ^ src_b;
            OP_SRL:  w_res = src_a >> w_sh_amt;
            OP_SRA:  w_res = $unsigned($signed(src_a) >>> w_sh_amt);
            OP_OR:   w_res = src_a | src_b;
            OP_AND:  w_res = src_a & src_b;
            OP_DIV:  w_res = w_dz ? '1 : src_a;
            OP_DIVU: w_res = '1;
            OP_REM:  w_res = w_dz ? src_a : '0;
            OP_REMU: w_res = src_a;
            default: w_res = '0;
        endcase
    end

    assign w_acc_nxt = r_mplier[0] ? r_acc + r_mcand : r_acc;
    assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
    assign w_mres    = (r_op == OP_MUL) ? w_prod[WIDTH-1:0]
                                        : w_prod[2*WIDTH-1:WIDTH];

    assign w_sh      = {r_rem, r_quo[WIDTH-1]};
    assign w_diff    = w_sh - {1'b0, r_dvs};
    assign w_qbit    = !w_diff[WIDTH];
    assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_sh[WIDTH-1:0];
    assign w_quo_nxt = {r_quo[WIDTH-2:0], w_qbit};
    assign w_q       = r_neg ? -w_quo_nxt : w_quo_nxt;
    assign w_r       = r_rneg ? -w_rem_nxt : w_rem_nxt;
    assign w_dres    = (r_op inside {OP_DIV, OP_DIVU}) ? w_q : w_r;

    always_comb begin
        w_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)
                w_nxt = w_single ? S_DONE : (w_is_mul ? S_MUL : S_DIV);
            S_MUL, S_DIV: if (r_cnt == CNT_MAX) w_nxt = S_DONE;
            default: if (out_ready) w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_op     <= OP_ADD;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ill    <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op     <= w_op;
                    r_cnt    <= '0;
                    r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
                    r_mplier <= w_mag_b;
                    r_acc    <= '0;
                    r_rem    <= '0;
                    r_quo    <= w_mag_a;
                    r_dvs    <= w_mag_b;
                    r_neg    <= w_a_sgn ^ w_b_sgn;
                    r_rneg   <= w_a_sgn;
                    if (w_single) begin
                        r_result <= w_res;
                        r_zero   <= (w_res == '0);
                        r_ill    <= (w_op == OP_ILL);
                    end
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_MAX) begin
                        r_result <= w_mres;
                        r_zero   <= (w_mres == '0);
                        r_ill    <= 1'b0;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_MAX) begin
                        r_result <= w_dres;
                        r_zero   <= (w_dres == '0);
                        r_ill    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign result    = r_result;
    assign zero      = r_zero;
    assign illegal   = r_ill;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: decode, mul/div, handshake, reset abort.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  ALUop = '0;
    logic [6:0]  funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] result2;
    logic        zero2;
    logic        illegal2;

    int n_checks = 0;
    int n_fail   = 0;

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .ALUop(ALUop), .funct7(funct7), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .zero(zero),
        .illegal(illegal)
    );

    alu_exec_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rstn(rstn), .in_valid(in_valid2), .in_ready(in_ready2),
        .ALUop(ALUop), .funct7(funct7), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .out_valid(out_valid2),
        .out_ready(out_ready2), .result(result2), .zero(zero2),
        .illegal(illegal2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input int hold,
                       output int lat, output logic [31:0] r,
                       output logic z, output logic il, output logic rdy);
        @(negedge clk);
        ALUop = op; funct7 = f7; funct3 = f3;
        src_a = a; src_b = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r = result; z = zero; il = illegal; rdy = in_ready;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_result", result, r);
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    int          lat;
    logic [31:0] r;
    logic        z, il, rdy;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_illegal", {31'b0, illegal}, 32'd0);
        rstn = 1'b1;

        run(2'b10, 7'b0100000, 3'b000, 32'd5, 32'd7, 0, lat, r, z, il, rdy);
        chk("sub_res", r, 32'hFFFFFFFE);
        chk("sub_zero", {31'b0, z}, 32'd0);
        chk("sub_lat", 32'(lat), 32'd1);
        chk("sub_busy", {31'b0, rdy}, 32'd0);
        chk("sub_rdy_after", {31'b0, in_ready}, 32'd1);

        run(2'b11, 7'b0100000, 3'b101, 32'h80000000, 32'd4, 0, lat, r, z, il, rdy);
        chk("srai", r, 32'hF8000000);
        run(2'b11, 7'b0000000, 3'b101, 32'h80000000, 32'd4, 0, lat, r, z, il, rdy);
        chk("srli", r, 32'h08000000);
        run(2'b00, 7'b0, 3'b000, 32'd3, 32'd4, 0, lat, r, z, il, rdy);
        chk("ld_add", r, 32'd7);
        run(2'b01, 7'b0, 3'b000, 32'd9, 32'd9, 0, lat, r, z, il, rdy);
        chk("br_sub", r, 32'd0);
        chk("br_zero", {31'b0, z}, 32'd1);
        run(2'b10, 7'b0, 3'b010, 32'hFFFFFFFF, 32'd1, 0, lat, r, z, il, rdy);
        chk("slt", r, 32'd1);
        run(2'b10, 7'b0, 3'b011, 32'hFFFFFFFF, 32'd1, 0, lat, r, z, il, rdy);
        chk("sltu", r, 32'd0);
        run(2'b10, 7'b0, 3'b001, 32'h00000003, 32'h00000024, 0, lat, r, z, il, rdy);
        chk("sll_shamt", r, 32'h00000030);
        run(2'b11, 7'b0000001, 3'b001, 32'd1, 32'd1, 0, lat, r, z, il, rdy);
        chk("slli_ill", {31'b0, il}, 32'd1);

        run(2'b10, 7'b0000001, 3'b001, 32'hFFFFFFFF, 32'd2, 0, lat, r, z, il, rdy);
        chk("mulh", r, 32'hFFFFFFFF);
        chk("mulh_lat", 32'(lat), 32'd33);
        run(2'b10, 7'b0000001, 3'b011, 32'hFFFFFFFF, 32'd2, 0, lat, r, z, il, rdy);
        chk("mulhu", r, 32'h00000001);
        run(2'b10, 7'b0000001, 3'b000, 32'hFFFFFFFF, 32'd2, 0, lat, r, z, il, rdy);
        chk("mul", r, 32'hFFFFFFFE);
        run(2'b10, 7'b0000001, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, lat, r, z, il, rdy);
        chk("mulhsu", r, 32'hFFFFFFFF);

        run(2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF9, 32'd2, 0, lat, r, z, il, rdy);
        chk("div", r, 32'hFFFFFFFD);
        chk("div_lat", 32'(lat), 32'd33);
        run(2'b10, 7'b0000001, 3'b110, 32'hFFFFFFF9, 32'd2, 0, lat, r, z, il, rdy);
        chk("rem", r, 32'hFFFFFFFF);
        chk("rem_lat", 32'(lat), 32'd33);
        run(2'b10, 7'b0000001, 3'b110, 32'd7, 32'hFFFFFFFE, 0, lat, r, z, il, rdy);
        chk("rem_pos", r, 32'd1);
        run(2'b10, 7'b0000001, 3'b100, 32'hFFFFFFF8, 32'hFFFFFFFE, 0, lat, r, z, il, rdy);
        chk("div_negneg", r, 32'd4);
        run(2'b10, 7'b0000001, 3'b101, 32'd55, 32'd0, 0, lat, r, z, il, rdy);
        chk("divu_dz", r, 32'hFFFFFFFF);
        chk("divu_dz_lat", 32'(lat), 32'd1);
        run(2'b10, 7'b0000001, 3'b111, 32'h1234, 32'd0, 0, lat, r, z, il, rdy);
        chk("remu_dz", r, 32'h1234);
        run(2'b10, 7'b0000001, 3'b100, 32'h80000000, 32'hFFFFFFFF, 0, lat, r, z, il, rdy);
        chk("div_ovf", r, 32'h80000000);
        chk("div_ovf_lat", 32'(lat), 32'd1);
        run(2'b10, 7'b0000001, 3'b110, 32'h80000000, 32'hFFFFFFFF, 0, lat, r, z, il, rdy);
        chk("rem_ovf", r, 32'd0);
        chk("rem_ovf_zero", {31'b0, z}, 32'd1);

        run(2'b10, 7'b0000011, 3'b000, 32'd5, 32'd6, 0, lat, r, z, il, rdy);
        chk("ill_flag", {31'b0, il}, 32'd1);
        chk("ill_res", r, 32'd0);

        @(negedge clk);
        ALUop = 2'b10; funct7 = 7'b0000001; funct3 = 3'b000;
        src_a = 32'd3; src_b = 32'd4; in_valid2 = 1'b1;
        @(negedge clk);
        in_valid2 = 1'b0;
        chk("nomul_valid", {31'b0, out_valid2}, 32'd1);
        chk("nomul_ill", {31'b0, illegal2}, 32'd1);
        chk("nomul_res", result2, 32'd0);

        run(2'b10, 7'b0, 3'b111, 32'h0000F0F0, 32'h0000FF00, 5, lat, r, z, il, rdy);
        chk("and_stall", r, 32'h0000F000);

        @(negedge clk);
        ALUop = 2'b10; funct7 = 7'b0000001; funct3 = 3'b100;
        src_a = 32'd100; src_b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd1);
        chk("abort_result", result, 32'd0);
        rstn = 1'b1;
        run(2'b10, 7'b0000001, 3'b101, 32'd100, 32'd7, 0, lat, r, z, il, rdy);
        chk("divu_after", r, 32'd14);
        chk("divu_after_lat", 32'(lat), 32'd33);
        run(2'b10, 7'b0000001, 3'b111, 32'd100, 32'd7, 0, lat, r, z, il, rdy);
        chk("remu_after", r, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
